// File: rtl/cu_ucode_pkg.sv
// Shared definitions for the microprogrammed control unit: microword field
// layout helpers, next-address mode encodings and sequencer state encoding.
package cu_ucode_pkg;

    localparam int NM_W = 2;

    typedef enum logic [NM_W-1:0] {
        NM_INC   = 2'b00,
        NM_JUMP  = 2'b01,
        NM_MAP   = 2'b10,
        NM_FETCH = 2'b11
    } next_mode_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_WAIT_OP = 2'b01,
        S_HALTED  = 2'b10
    } state_t;

    // Microword layout, LSB first: ctrl | alu_op | next_mode | mar_inc | halt | branch
    function automatic int off_alu(input int num_ctrl);
        return num_ctrl;
    endfunction

    function automatic int off_nm(input int num_ctrl, input int alu_op_w);
        return num_ctrl + alu_op_w;
    endfunction

    function automatic int off_mar(input int num_ctrl, input int alu_op_w);
        return num_ctrl + alu_op_w + NM_W;
    endfunction

    function automatic int off_halt(input int num_ctrl, input int alu_op_w);
        return num_ctrl + alu_op_w + NM_W + 1;
    endfunction

    function automatic int off_br(input int num_ctrl, input int alu_op_w);
        return num_ctrl + alu_op_w + NM_W + 2;
    endfunction

    function automatic int cw_width(input int num_ctrl, input int alu_op_w, input int addr_w);
        return num_ctrl + alu_op_w + NM_W + 2 + addr_w;
    endfunction

endpackage

// File: rtl/cu_next_addr_gen.sv
// Combinational next-microaddress generator: sequential, branch, opcode map
// and fetch targets selected by the microword's next_mode field.
module cu_next_addr_gen
    import cu_ucode_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int OPCODE_W   = 8,
    parameter int FETCH_ADDR = 0,
    parameter int MAP_BASE   = 16,
    parameter int MAP_SHIFT  = 2
) (
    input  logic [ADDR_W-1:0]   car,
    input  next_mode_t          next_mode,
    input  logic [ADDR_W-1:0]   branch,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   next_car,
    output logic [ADDR_W-1:0]   map_tgt
);

    localparam int SH_W = OPCODE_W + MAP_SHIFT;

    logic [SH_W-1:0] op_sh;

    // Dispatch table entries are 2**MAP_SHIFT words apart; the sum wraps.
    assign op_sh   = SH_W'(opcode) << MAP_SHIFT;
    assign map_tgt = ADDR_W'(MAP_BASE) + ADDR_W'(op_sh);

    always_comb begin
        next_car = car + ADDR_W'(1);
        case (next_mode)
            NM_INC:   next_car = car + ADDR_W'(1);
            NM_JUMP:  next_car = branch;
            NM_MAP:   next_car = map_tgt;
            NM_FETCH: next_car = ADDR_W'(FETCH_ADDR);
            default:  next_car = car + ADDR_W'(1);
        endcase
    end

endmodule

// File: rtl/cu_microsequencer_cbr.sv
// Control address register, control buffer register and sequencing FSM for
// the microprogrammed CU. Each loaded microword drives its outputs for one cycle.
//
//   state     | meaning
//   S_RUN     | load microword at CAR each unstalled cycle
//   S_WAIT_OP | MAP word executed, waiting for a valid opcode to dispatch
//   S_HALTED  | halt word executed; frozen until resume_i
module cu_microsequencer_cbr
    import cu_ucode_pkg::*;
#(
    parameter int NUM_CTRL   = 16,
    parameter int ALU_OP_W   = 4,
    parameter int ADDR_W     = 8,
    parameter int OPCODE_W   = 8,
    parameter int FETCH_ADDR = 0,
    parameter int MAP_BASE   = 16,
    parameter int MAP_SHIFT  = 2,
    localparam int CW        = NUM_CTRL + ALU_OP_W + 4 + ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   cm_addr_o,
    input  logic [CW-1:0]       cm_data_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                opcode_valid_i,
    output logic                opcode_ack_o,
    input  logic                stall_i,
    input  logic                resume_i,
    output logic [NUM_CTRL-1:0] ctrl_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                mar_inc_o,
    output logic                halt_o,
    output logic                word_valid_o
);

    localparam int OFF_ALU  = off_alu(NUM_CTRL);
    localparam int OFF_NM   = off_nm(NUM_CTRL, ALU_OP_W);
    localparam int OFF_MAR  = off_mar(NUM_CTRL, ALU_OP_W);
    localparam int OFF_HALT = off_halt(NUM_CTRL, ALU_OP_W);
    localparam int OFF_BR   = off_br(NUM_CTRL, ALU_OP_W);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   car, car_n;
    logic [NUM_CTRL-1:0] cbr_ctrl, cbr_ctrl_n;
    logic [ALU_OP_W-1:0] cbr_alu, cbr_alu_n;
    logic                cbr_mar, cbr_mar_n;
    logic                word_valid, word_valid_n;
    logic                ack, ack_n;

    next_mode_t          in_mode, eff_mode;
    logic                in_halt;
    logic [ADDR_W-1:0]   in_branch, next_car, map_tgt;

    assign in_mode   = next_mode_t'(cm_data_i[OFF_NM +: NM_W]);
    assign in_halt   = cm_data_i[OFF_HALT];
    assign in_branch = cm_data_i[OFF_BR +: ADDR_W];
    // A halting word must not consume an opcode, so MAP degrades to FETCH.
    assign eff_mode  = (in_halt && in_mode == NM_MAP) ? NM_FETCH : in_mode;

    cu_next_addr_gen #(
        .ADDR_W     (ADDR_W),
        .OPCODE_W   (OPCODE_W),
        .FETCH_ADDR (FETCH_ADDR),
        .MAP_BASE   (MAP_BASE),
        .MAP_SHIFT  (MAP_SHIFT)
    ) u_next_addr (
        .car        (car),
        .next_mode  (eff_mode),
        .branch     (in_branch),
        .opcode     (opcode_i),
        .next_car   (next_car),
        .map_tgt    (map_tgt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            car        <= ADDR_W'(FETCH_ADDR);
            cbr_ctrl   <= '0;
            cbr_alu    <= '0;
            cbr_mar    <= 1'b0;
            word_valid <= 1'b0;
            ack        <= 1'b0;
        end else begin
            state      <= state_n;
            car        <= car_n;
            cbr_ctrl   <= cbr_ctrl_n;
            cbr_alu    <= cbr_alu_n;
            cbr_mar    <= cbr_mar_n;
            word_valid <= word_valid_n;
            ack        <= ack_n;
        end
    end

    always_comb begin
        state_n      = state;
        car_n        = car;
        cbr_ctrl_n   = cbr_ctrl;
        cbr_alu_n    = cbr_alu;
        cbr_mar_n    = cbr_mar;
        word_valid_n = 1'b0;
        ack_n        = 1'b0;
        case (state)
            S_RUN: begin
                if (!stall_i) begin
                    cbr_ctrl_n   = cm_data_i[NUM_CTRL-1:0];
                    cbr_alu_n    = cm_data_i[OFF_ALU +: ALU_OP_W];
                    cbr_mar_n    = cm_data_i[OFF_MAR];
                    word_valid_n = 1'b1;
                    if (in_halt) begin
                        car_n   = next_car;
                        state_n = S_HALTED;
                    end else if (in_mode == NM_MAP) begin
                        if (opcode_valid_i) begin
                            car_n = map_tgt;
                            ack_n = 1'b1;
                        end else begin
                            state_n = S_WAIT_OP;
                        end
                    end else begin
                        car_n = next_car;
                    end
                end
            end
            S_WAIT_OP: begin
                if (opcode_valid_i && !stall_i) begin
                    car_n   = map_tgt;
                    ack_n   = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_HALTED: begin
                if (resume_i) state_n = S_RUN;
            end
            default: state_n = S_RUN;
        endcase
    end

    assign cm_addr_o    = car;
    assign word_valid_o = word_valid;
    assign opcode_ack_o = ack;
    assign halt_o       = (state == S_HALTED);
    assign ctrl_o       = word_valid ? cbr_ctrl : '0;
    assign alu_op_o     = word_valid ? cbr_alu : '0;
    assign mar_inc_o    = word_valid & cbr_mar;

endmodule
